// File: rtl/wash_pkg.sv
`default_nettype none
// ============================================================================
// wash_pkg - shared washer-controller encodings (modes, panel FSM, digit map)
// Revision: 1.0
// ============================================================================
package wash_pkg;

  localparam logic [1:0] MODE_SPIN  = 2'b00;
  localparam logic [1:0] MODE_SMALL = 2'b01;
  localparam logic [1:0] MODE_MED   = 2'b10;
  localparam logic [1:0] MODE_LARGE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HELD      = 2'd1,
    ST_LONG_WAIT = 2'd2
  } panel_state_e;

  // Nibble k holds the display digit for mode k.
  localparam logic [15:0] MODE_DIGIT_MAP = {4'd4, 4'd3, 4'd2, 4'd1};

  function automatic logic [3:0] mode_to_digit(input logic [1:0] m);
    return MODE_DIGIT_MAP[{m, 2'b00} +: 4];
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// btn_debounce - 2-flop synchronizer plus stability-counter debouncer
// Revision: 1.0
// ============================================================================
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bt,
  output logic db,
  output logic db_rise,
  output logic db_fall
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q, db_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = bt;
    sync2_d = sync1_q;
    db_d    = db_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    cnt_d   = '0;
    // Counter only runs while the synced level disagrees; any agreement clears it.
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d   = sync2_q;
        rise_d = sync2_q;
        fall_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db      = db_q;
  assign db_rise = rise_q;
  assign db_fall = fall_q;

endmodule
`default_nettype wire

// File: rtl/mode_panel.sv
`default_nettype none
// ============================================================================
// mode_panel - short press cycles wash mode, long press pulses start
// Revision: 1.0
// ============================================================================
module mode_panel
  import wash_pkg::*;
#(
  parameter int         DEBOUNCE_CYC = 2_000_000,
  parameter int         LONG_CYC     = 100_000_000,
  parameter logic [1:0] DEFAULT_MODE = 2'b10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bt,
  input  logic       busy,
  output logic [1:0] mode,
  output logic       start,
  output logic [3:0] mode_digit,
  output logic       press_led
);

  localparam int                HOLD_W    = $clog2(LONG_CYC + 1);
  localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYC);

  logic              db, db_rise, db_fall;
  logic              short_evt, long_evt;
  panel_state_e      state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic              start_q, start_d;

  btn_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_btn_debounce (
    .clk     (clk),
    .rst_n   (rst),
    .bt      (bt),
    .db      (db),
    .db_rise (db_rise),
    .db_fall (db_fall)
  );

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    short_evt  = 1'b0;
    long_evt   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (db_rise) begin
          state_d    = ST_HELD;
          hold_cnt_d = '0;
        end
      end
      ST_HELD: begin
        if (hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + 1'b1;
        if (db_fall) begin
          short_evt = (hold_cnt_q < HOLD_MAX);
          state_d   = ST_IDLE;
        end else if (db && (hold_cnt_q == HOLD_LONG)) begin
          long_evt = 1'b1;
          state_d  = ST_LONG_WAIT;
        end
      end
      ST_LONG_WAIT: begin
        if (db_fall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // busy is judged in the event cycle only; a blocked event is simply dropped.
  always_comb begin
    mode_d  = mode_q;
    start_d = long_evt && !busy;
    if (short_evt && !busy) begin
      case (mode_q)
        MODE_SPIN:  mode_d = MODE_SMALL;
        MODE_SMALL: mode_d = MODE_MED;
        MODE_MED:   mode_d = MODE_LARGE;
        MODE_LARGE: mode_d = MODE_SPIN;
        default:    mode_d = DEFAULT_MODE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      mode_q     <= DEFAULT_MODE;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      mode_q     <= mode_d;
      start_q    <= start_d;
    end
  end

  assign mode       = mode_q;
  assign start      = start_q;
  assign press_led  = (state_q != ST_IDLE);
  assign mode_digit = mode_to_digit(mode_q);

endmodule
`default_nettype wire

// File: tb/tb_mode_panel.sv
`default_nettype none
// ============================================================================
// tb_mode_panel - directed self-checking bench (DEBOUNCE_CYC=4, LONG_CYC=20)
// Revision: 1.0
// ============================================================================
module tb_mode_panel;

  logic       clk = 1'b0;
  logic       rst;
  logic       bt;
  logic       busy;
  logic [1:0] mode;
  logic       start;
  logic [3:0] mode_digit;
  logic       press_led;
  logic [7:0] obs;
  logic [7:0] exp_v;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mode_panel #(
    .DEBOUNCE_CYC (4),
    .LONG_CYC     (20),
    .DEFAULT_MODE (2'b10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bt         (bt),
    .busy       (busy),
    .mode       (mode),
    .start      (start),
    .mode_digit (mode_digit),
    .press_led  (press_led)
  );

  // {mode, start, press_led, mode_digit}
  assign obs = {mode, start, press_led, mode_digit};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; bt = 1'b0; busy = 1'b0;
    repeat (3) tick();
    checks++;
    if (obs !== 8'b10_0_0_0011) begin
      errors++;
      $display("FAIL reset_held: got %b want %b", obs, 8'b10_0_0_0011);
    end
    rst = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      tick();
      checks++;
      if (obs !== 8'b10_0_0_0011) begin
        errors++;
        $display("FAIL reset_idle n=%0d: got %b want %b", n, obs, 8'b10_0_0_0011);
      end
    end
  endtask

  task automatic test_short_press();
    // First press 10 -> 11, second press wraps 11 -> 00.
    bt = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      tick();
      exp_v = (n >= 17) ? {2'b11, 1'b0, 1'b0, 4'd4}
                        : {2'b10, 1'b0, (n >= 7), 4'd3};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL short1 n=%0d: got %b want %b", n, obs, exp_v);
      end
      if (n == 10) bt = 1'b0;
    end
    bt = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      tick();
      exp_v = (n >= 17) ? {2'b00, 1'b0, 1'b0, 4'd1}
                        : {2'b11, 1'b0, (n >= 7), 4'd4};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL short_wrap n=%0d: got %b want %b", n, obs, exp_v);
      end
      if (n == 10) bt = 1'b0;
    end
  endtask

  task automatic test_long_press();
    bt = 1'b1;
    for (int n = 1; n <= 55; n++) begin
      tick();
      exp_v = {2'b00, (n == 27), (n >= 7 && n <= 46), 4'd1};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL long n=%0d: got %b want %b", n, obs, exp_v);
      end
      if (n == 40) bt = 1'b0;
    end
  endtask

  task automatic test_bounce();
    for (int n = 0; n < 45; n++) begin
      bt = (n < 30) && (((n / 2) % 2) == 0);
      tick();
      checks++;
      if (obs !== 8'b00_0_0_0001) begin
        errors++;
        $display("FAIL bounce n=%0d: got %b want %b", n, obs, 8'b00_0_0_0001);
      end
    end
    bt = 1'b0;
  endtask

  task automatic test_busy();
    busy = 1'b1;
    bt   = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      tick();
      exp_v = {2'b00, 1'b0, (n >= 7 && n <= 16), 4'd1};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL busy_short n=%0d: got %b want %b", n, obs, exp_v);
      end
      if (n == 10) bt = 1'b0;
    end
    bt = 1'b1;
    for (int n = 1; n <= 55; n++) begin
      tick();
      exp_v = {2'b00, 1'b0, (n >= 7 && n <= 46), 4'd1};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL busy_long n=%0d: got %b want %b", n, obs, exp_v);
      end
      if (n == 40) bt = 1'b0;
    end
    // busy drops mid-hold, before the long threshold
    bt = 1'b1;
    for (int n = 1; n <= 55; n++) begin
      tick();
      exp_v = {2'b00, (n == 27), (n >= 7 && n <= 46), 4'd1};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL busy_drop n=%0d: got %b want %b", n, obs, exp_v);
      end
      if (n == 15) busy = 1'b0;
      if (n == 40) bt = 1'b0;
    end
  endtask

  task automatic test_reset_mid_hold();
    bt = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      tick();
      exp_v = {2'b00, 1'b0, (n >= 7), 4'd1};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL pre_reset n=%0d: got %b want %b", n, obs, exp_v);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== 8'b10_0_0_0011) begin
      errors++;
      $display("FAIL async_reset: got %b want %b", obs, 8'b10_0_0_0011);
    end
    repeat (3) tick();
    rst = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      exp_v = {2'b10, (n == 27), (n >= 7), 4'd3};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL post_reset n=%0d: got %b want %b", n, obs, exp_v);
      end
    end
    bt = 1'b0;
    repeat (12) tick();
    checks++;
    if (obs !== 8'b10_0_0_0011) begin
      errors++;
      $display("FAIL post_release: got %b want %b", obs, 8'b10_0_0_0011);
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_long_press();
    test_bounce();
    test_busy();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mode_panel.md
Name: mode_panel

Overview:
Front-panel input decoder for the washer controller. It takes the raw mid-button level and classifies each press as short or long. A short press cycles the wash-program selection; a long press issues a one-cycle start pulse. Outputs are the 2-bit `mode` and `start` consumed by the wash sequencer, plus a display digit for the 4-digit 7-segment scanner.

Parameters:
- DEBOUNCE_CYC, 2_000_000: consecutive stable cycles needed to accept a new button level (20 ms at 100 MHz).
- LONG_CYC, 100_000_000: debounced-high cycles that qualify a press as long (1 s at 100 MHz).
- DEFAULT_MODE, 2'b10: mode after reset (00 spin-only, 01 small, 10 medium, 11 large).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- bt  in  1  raw push-button level, asynchronous to clk, active-high.
- busy  in  1  high while the sequencer is not in its setup phase; blocks mode change and start.
- mode  out  2  selected program.
- start  out  1  one-cycle pulse requesting program start.
- mode_digit  out  4  display code for the selected mode: 00→1, 01→2, 10→3, 11→4.
- press_led  out  1  high while a debounced press is held.

Behaviour:
- Reset (rst low, asynchronous):
  - mode=DEFAULT_MODE, start=0, press_led=0, mode_digit=3.
  - Synchronizer flops, debounced level and counters all cleared; FSM=IDLE.
- Input path:
  - 2-flop synchronizer on bt, then debouncer.
  - Debounced level db changes only after the synchronized level differs from db for DEBOUNCE_CYC consecutive cycles.
  - Any bounce back to db's value clears the stability counter.
  - Latency from a clean bt edge to the db edge is 2+DEBOUNCE_CYC cycles.
- Events: db_rise and db_fall are single-cycle pulses derived from db.
- FSM states IDLE, HELD, LONG_WAIT:
  - IDLE: on db_rise → HELD; clear hold_cnt.
  - HELD: hold_cnt increments each cycle.
    - db_fall with hold_cnt < LONG_CYC → short press; → IDLE.
    - hold_cnt reaches LONG_CYC−1 while db high → long press; → LONG_WAIT.
  - LONG_WAIT: ignore everything until db_fall, then → IDLE. No action on that release.
- Actions, registered and taking effect the cycle after the event:
  - Short press with busy=0: mode ← mode+1, modulo 4 (11 wraps to 00).
  - Long press with busy=0: start=1 for exactly one cycle; mode unchanged.
  - busy is sampled in the event cycle itself. If busy=1 there, the event is discarded; the FSM still advances normally and no action is deferred.
- hold_cnt is $clog2(LONG_CYC+1) bits and saturates; it never wraps.
- press_led = 1 in HELD and LONG_WAIT, 0 in IDLE.
- mode_digit is combinational from mode.
- Reset mid-press: all state is cleared. A button still held when reset deasserts is seen as a fresh press once debounced, and hold timing restarts from that db_rise.
- start can never be asserted on two consecutive cycles. At least one release and a new press are required between start pulses.

Decomposition:
- Shared package wash_pkg holds:
  - mode encodings MODE_SPIN=2'b00, MODE_SMALL=2'b01, MODE_MED=2'b10, MODE_LARGE=2'b11;
  - the panel FSM state enum;
  - the mode→digit mapping constant.
- Sub-module btn_debounce (synchronizer plus stability counter; parameter DEBOUNCE_CYC; outputs db, db_rise, db_fall). It is reusable for future panel buttons.

Test Plan (bench overrides DEBOUNCE_CYC=4, LONG_CYC=20):
1. Reset release, no activity → mode=2'b10, mode_digit=3, start=0 and press_led=0 for 100 cycles.
2. bt high 10 cycles, then low, busy=0 → mode becomes 2'b11 one cycle after the debounced fall; press repeated → mode=2'b00, mode_digit=1 (wrap).
3. bt high 40 cycles, busy=0 → start pulses exactly once, 1 cycle wide, about cycle 2+4+20 after the bt rise; mode unchanged; no further pulse on release.
4. bt toggles every 2 cycles for 30 cycles, then stays low → db never rises, mode and start unchanged, press_led=0 throughout.
5. busy=1, then a short press and a long press → mode and start unchanged. busy drops mid-hold before the long threshold → start fires at the threshold.
6. bt held, rst pulsed low for 3 cycles mid-hold → all outputs at reset values immediately. The new press is detected 2+4 cycles after rst rises, and start fires 20 cycles after that if still held.
